// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
// Shared constants and types for the 1:8 TDM demultiplexer.
//   NUM_SLOTS  : number of time slots per frame
//   SLOT_W     : width of a slot index
//   state_e    : framing FSM encoding (HUNT = 0, LOCKED = 1)
//   isLastSlot : true when a slot index addresses the final slot of a frame
// ---------------------------------------------------------------------------
package tdm_pkg;

    localparam int unsigned NUM_SLOTS = 8;
    localparam int unsigned SLOT_W    = 3;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    function automatic logic isLastSlot(input logic [SLOT_W-1:0] slot);
        return (slot == LAST_SLOT);
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// ---------------------------------------------------------------------------
// tdm_slot_counter
// Slot index counter for the TDM demultiplexer. Wraps naturally from the last
// slot back to 0 because NUM_SLOTS is a power of two filling SLOT_W bits.
// Priority: clear > load-to-1 > increment.
//
// Ports:
//   clk_i    in   rising-edge clock
//   rst_ni   in   asynchronous active-low reset (count -> 0)
//   clear_i  in   synchronous clear to slot 0
//   load_i   in   synchronous load of slot 1 (slot 0 was just consumed)
//   en_i     in   increment by one (modulo NUM_SLOTS)
//   count_o  out  current slot index
// ---------------------------------------------------------------------------
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              en_i,
    output logic [SLOT_W-1:0] count_o
);

    logic [SLOT_W-1:0] count_q;
    logic [SLOT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = SLOT_W'(1);
        end else if (en_i) begin
            count_d = count_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/tdm_demux_1_8.sv
// ---------------------------------------------------------------------------
// tdm_demux_1_8
// Serial 1:8 time-division demultiplexer. A frame sync (qualified by valid)
// marks slot 0; the following valid samples fill slots 1..7. When slot 7 is
// sampled the whole frame is presented on Data_0..7_Out at once together with
// a one-cycle Frame_Valid_Out pulse. Partial frames are held in a shadow
// register and never reach the outputs.
//
// Optional feature (macro TDM_DEMUX_SYNC_CHECK_EN):
//   In LOCKED, a valid sync at a slot other than 0 sets a sticky
//   Sync_Error_Out, discards the partial frame and restarts at slot 1 with the
//   sync sample as slot 0. RESYNC_LIMIT consecutive misplaced syncs (no
//   complete frame between them) drop the FSM back to HUNT.
//   Without the macro, syncs are ignored in LOCKED and Sync_Error_Out is 0.
//
// Parameters:
//   RESYNC_LIMIT     misplaced syncs tolerated before HUNT (macro build only)
// Ports:
//   Clock_In         in   rising-edge clock
//   Reset_N_In       in   asynchronous active-low reset
//   Enable_In        in   block enable; low = data outputs Z, FSM to HUNT
//   Serial_Data_In   in   TDM data bit, one slot per valid cycle
//   Data_Valid_In    in   qualifies Serial_Data_In and Frame_Sync_In
//   Frame_Sync_In    in   current valid sample is slot 0
//   Data_0..7_Out    out  registered slot values (Z while disabled)
//   Frame_Valid_Out  out  one-cycle pulse when Data_x_Out updates
//   Slot_Out         out  slot index of the next expected sample
//   Locked_Out       out  high in LOCKED
//   Sync_Error_Out   out  sticky misplaced-sync flag
// ---------------------------------------------------------------------------
module tdm_demux_1_8
    import tdm_pkg::*;
#(
    parameter int unsigned RESYNC_LIMIT = 3
) (
    input  logic              Clock_In,
    input  logic              Reset_N_In,
    input  logic              Enable_In,
    input  logic              Serial_Data_In,
    input  logic              Data_Valid_In,
    input  logic              Frame_Sync_In,
    output logic              Data_0_Out,
    output logic              Data_1_Out,
    output logic              Data_2_Out,
    output logic              Data_3_Out,
    output logic              Data_4_Out,
    output logic              Data_5_Out,
    output logic              Data_6_Out,
    output logic              Data_7_Out,
    output logic              Frame_Valid_Out,
    output logic [SLOT_W-1:0] Slot_Out,
    output logic              Locked_Out,
    output logic              Sync_Error_Out
);

    state_e                 state_q;
    state_e                 state_d;
    logic [NUM_SLOTS-2:0]   shadow_q;
    logic [NUM_SLOTS-2:0]   shadow_d;
    logic [NUM_SLOTS-1:0]   data_q;
    logic [NUM_SLOTS-1:0]   data_d;
    logic                   frameValid_q;
    logic                   frameValid_d;

    logic [SLOT_W-1:0]      slot;
    logic                   slotClear;
    logic                   slotLoad;
    logic                   slotInc;

    logic                   lockedSample;
    logic                   misplacedSync;
    logic                   resyncExhausted;

    assign lockedSample = Enable_In && Data_Valid_In && (state_q == LOCKED);

    tdm_slot_counter u_slotCounter (
        .clk_i   (Clock_In),
        .rst_ni  (Reset_N_In),
        .clear_i (slotClear),
        .load_i  (slotLoad),
        .en_i    (slotInc),
        .count_o (slot)
    );

`ifdef TDM_DEMUX_SYNC_CHECK_EN
    localparam int unsigned   CNT_W = $clog2(RESYNC_LIMIT + 1);
    localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(RESYNC_LIMIT);

    logic [CNT_W-1:0] missCount_q;
    logic [CNT_W-1:0] missCount_d;
    logic [CNT_W:0]   missNext;
    logic             syncError_q;
    logic             syncError_d;

    assign misplacedSync   = Frame_Sync_In && (slot != '0);
    assign missNext        = {1'b0, missCount_q} + (CNT_W + 1)'(1);
    assign resyncExhausted = (missNext >= LIMIT);

    // The miss count only tracks consecutive misplaced syncs: a completed
    // frame or losing enable starts the count again.
    always_comb begin
        missCount_d = missCount_q;
        syncError_d = syncError_q;
        if (!Enable_In) begin
            missCount_d = '0;
        end else if (lockedSample) begin
            if (misplacedSync) begin
                syncError_d = 1'b1;
                missCount_d = resyncExhausted ? '0 : missNext[CNT_W-1:0];
            end else if (isLastSlot(slot)) begin
                missCount_d = '0;
            end
        end
    end

    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            missCount_q <= '0;
            syncError_q <= 1'b0;
        end else begin
            missCount_q <= missCount_d;
            syncError_q <= syncError_d;
        end
    end

    assign Sync_Error_Out = syncError_q;
`else
    assign misplacedSync   = 1'b0;
    assign resyncExhausted = 1'b0;
    // Constant 0; the parameter term folds away and keeps the parameter
    // referenced in a build where it has no function.
    assign Sync_Error_Out  = (RESYNC_LIMIT == 0) & 1'b0;
`endif

    // Framing FSM and datapath next-state. Frame_Valid defaults low so it
    // can only ever be a single-cycle pulse.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        data_d       = data_q;
        frameValid_d = 1'b0;
        slotClear    = 1'b0;
        slotLoad     = 1'b0;
        slotInc      = 1'b0;

        if (!Enable_In) begin
            state_d   = HUNT;
            slotClear = 1'b1;
        end else if (Data_Valid_In) begin
            case (state_q)
                HUNT: begin
                    if (Frame_Sync_In) begin
                        shadow_d[0] = Serial_Data_In;
                        slotLoad    = 1'b1;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (misplacedSync) begin
                        if (resyncExhausted) begin
                            state_d   = HUNT;
                            slotClear = 1'b1;
                        end else begin
                            shadow_d[0] = Serial_Data_In;
                            slotLoad    = 1'b1;
                        end
                    end else begin
                        slotInc = 1'b1;
                        // Last slot bypasses the shadow so the full frame
                        // lands on the outputs at the same edge.
                        if (isLastSlot(slot)) begin
                            data_d       = {Serial_Data_In, shadow_q};
                            frameValid_d = 1'b1;
                        end else begin
                            shadow_d[slot] = Serial_Data_In;
                        end
                    end
                end
                default: begin
                    state_d   = HUNT;
                    slotClear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q      <= HUNT;
            shadow_q     <= '0;
            data_q       <= '0;
            frameValid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            data_q       <= data_d;
            frameValid_q <= frameValid_d;
        end
    end

    // Disabling only floats the pins; data_q keeps the last frame.
    assign Data_0_Out = Enable_In ? data_q[0] : 1'bz;
    assign Data_1_Out = Enable_In ? data_q[1] : 1'bz;
    assign Data_2_Out = Enable_In ? data_q[2] : 1'bz;
    assign Data_3_Out = Enable_In ? data_q[3] : 1'bz;
    assign Data_4_Out = Enable_In ? data_q[4] : 1'bz;
    assign Data_5_Out = Enable_In ? data_q[5] : 1'bz;
    assign Data_6_Out = Enable_In ? data_q[6] : 1'bz;
    assign Data_7_Out = Enable_In ? data_q[7] : 1'bz;

    assign Frame_Valid_Out = frameValid_q & Enable_In;
    assign Slot_Out        = slot;
    assign Locked_Out      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_1_8.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_1_8
// Directed self-checking bench for tdm_demux_1_8. Expected values are hand
// computed from two reference frames:
//   frameA = slots 0..7 : 1,0,1,1,0,0,1,0  -> {D7..D0} = 8'h4D
//   frameB = slots 0..7 : 0,1,0,0,1,1,0,1  -> {D7..D0} = 8'hB2
// Macro-dependent expectations follow TDM_DEMUX_SYNC_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_tdm_demux_1_8;

    logic       Clock_In;
    logic       Reset_N_In;
    logic       Enable_In;
    logic       Serial_Data_In;
    logic       Data_Valid_In;
    logic       Frame_Sync_In;
    wire        Data_0_Out;
    wire        Data_1_Out;
    wire        Data_2_Out;
    wire        Data_3_Out;
    wire        Data_4_Out;
    wire        Data_5_Out;
    wire        Data_6_Out;
    wire        Data_7_Out;
    wire        Frame_Valid_Out;
    wire  [2:0] Slot_Out;
    wire        Locked_Out;
    wire        Sync_Error_Out;

    logic [7:0] dOut;
    int         nAsserts;
    int         nFail;

    localparam logic [7:0] FRAME_A = 8'h4D;
    localparam logic [7:0] FRAME_B = 8'hB2;

`ifdef TDM_DEMUX_SYNC_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    assign dOut = {Data_7_Out, Data_6_Out, Data_5_Out, Data_4_Out,
                   Data_3_Out, Data_2_Out, Data_1_Out, Data_0_Out};

    tdm_demux_1_8 #(.RESYNC_LIMIT(3)) dut (
        .Clock_In        (Clock_In),
        .Reset_N_In      (Reset_N_In),
        .Enable_In       (Enable_In),
        .Serial_Data_In  (Serial_Data_In),
        .Data_Valid_In   (Data_Valid_In),
        .Frame_Sync_In   (Frame_Sync_In),
        .Data_0_Out      (Data_0_Out),
        .Data_1_Out      (Data_1_Out),
        .Data_2_Out      (Data_2_Out),
        .Data_3_Out      (Data_3_Out),
        .Data_4_Out      (Data_4_Out),
        .Data_5_Out      (Data_5_Out),
        .Data_6_Out      (Data_6_Out),
        .Data_7_Out      (Data_7_Out),
        .Frame_Valid_Out (Frame_Valid_Out),
        .Slot_Out        (Slot_Out),
        .Locked_Out      (Locked_Out),
        .Sync_Error_Out  (Sync_Error_Out)
    );

    initial begin
        Clock_In = 1'b0;
        forever #5 Clock_In = ~Clock_In;
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One sample per clock; outputs are checked 1 time unit after the edge.
    task automatic applyStimulus(input logic v, input logic s, input logic d);
        Data_Valid_In  = v;
        Frame_Sync_In  = s;
        Serial_Data_In = d;
        @(posedge Clock_In);
        #1;
        Data_Valid_In  = 1'b0;
        Frame_Sync_In  = 1'b0;
    endtask

    initial begin
        int pulses;
        int firstPulse;
        int lastPulse;
        logic bitVal;

        nAsserts       = 0;
        nFail          = 0;
        Reset_N_In     = 1'b0;
        Enable_In      = 1'b1;
        Serial_Data_In = 1'b0;
        Data_Valid_In  = 1'b0;
        Frame_Sync_In  = 1'b0;

        // Reset state
        repeat (3) @(posedge Clock_In);
        #1;
        checkOutput("rst_data", dOut, 8'h00);
        checkBit("rst_fv", Frame_Valid_Out, 1'b0);
        checkBit("rst_locked", Locked_Out, 1'b0);
        checkBit("rst_syncerr", Sync_Error_Out, 1'b0);
        checkOutput("rst_slot", {5'd0, Slot_Out}, 8'd0);
        Reset_N_In = 1'b1;
        @(posedge Clock_In);
        #1;

        // Samples without sync are ignored in HUNT
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            if (Frame_Valid_Out === 1'b1) pulses++;
        end
        checkBit("hunt_locked", Locked_Out, 1'b0);
        checkOutput("hunt_pulses", 8'(pulses), 8'd0);
        checkOutput("hunt_data", dOut, 8'h00);
        checkOutput("hunt_slot", {5'd0, Slot_Out}, 8'd0);

        // Basic frame A
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, i == 0, FRAME_A[i]);
            if (i == 0) checkBit("a_locked", Locked_Out, 1'b1);
            if (i == 6) checkBit("a_fv_early", Frame_Valid_Out, 1'b0);
        end
        checkBit("a_fv", Frame_Valid_Out, 1'b1);
        checkOutput("a_data", dOut, FRAME_A);
        checkOutput("a_slot_wrap", {5'd0, Slot_Out}, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkBit("a_fv_once", Frame_Valid_Out, 1'b0);
        checkOutput("a_data_hold", dOut, FRAME_A);

        // Frame B, no gaps
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, i == 0, FRAME_B[i]);
        checkBit("b_fv", Frame_Valid_Out, 1'b1);
        checkOutput("b_data", dOut, FRAME_B);

        // Frame A with two invalid cycles after slot 3; a sync during the gap
        // is ignored because valid is low
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, i == 0, FRAME_A[i]);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("gap_slot", {5'd0, Slot_Out}, 8'd4);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("gap_slot_hold", {5'd0, Slot_Out}, 8'd4);
        checkOutput("gap_data_hold", dOut, FRAME_B);
        checkBit("gap_fv", Frame_Valid_Out, 1'b0);
        for (int i = 4; i < 8; i++) applyStimulus(1'b1, 1'b0, FRAME_A[i]);
        checkBit("gap_fv_end", Frame_Valid_Out, 1'b1);
        checkOutput("gap_data", dOut, FRAME_A);

        // 16 back-to-back valid cycles: frame B then frame A
        pulses     = 0;
        firstPulse = -1;
        lastPulse  = -1;
        for (int c = 0; c < 16; c++) begin
            bitVal = (c < 8) ? FRAME_B[c] : FRAME_A[c - 8];
            applyStimulus(1'b1, (c == 0) || (c == 8), bitVal);
            if (Frame_Valid_Out === 1'b1) begin
                pulses++;
                if (firstPulse < 0) firstPulse = c;
                lastPulse = c;
            end
            if (c == 7) checkOutput("b2b_data1", dOut, FRAME_B);
        end
        checkOutput("b2b_pulses", 8'(pulses), 8'd2);
        checkOutput("b2b_first", 8'(firstPulse), 8'd7);
        checkOutput("b2b_spacing", 8'(lastPulse - firstPulse), 8'd8);
        checkOutput("b2b_data2", dOut, FRAME_A);

        // Misplaced sync at slot 5, then the rest of frame A
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, i == 0, FRAME_B[i]);
        applyStimulus(1'b1, 1'b1, FRAME_A[0]);
        checkBit("mis_err", Sync_Error_Out, CHECK_ON);
        checkOutput("mis_slot", {5'd0, Slot_Out}, CHECK_ON ? 8'd1 : 8'd6);
        checkBit("mis_locked", Locked_Out, 1'b1);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, FRAME_A[i]);
            if (i == 2) begin
                checkBit("mis_fv2", Frame_Valid_Out, !CHECK_ON);
                if (!CHECK_ON) checkOutput("mis_data_off", dOut, FRAME_B);
            end
        end
        checkBit("mis_fv7", Frame_Valid_Out, CHECK_ON);
        checkOutput("mis_data7", dOut, CHECK_ON ? FRAME_A : FRAME_B);

        // Three consecutive misplaced syncs
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            applyStimulus(1'b1, 1'b1, 1'b1);
            checkBit("resync_locked", Locked_Out, CHECK_ON ? (k < 2) : 1'b1);
            checkBit("resync_err", Sync_Error_Out, CHECK_ON);
        end

        // Disable returns both builds to HUNT
        Enable_In = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        Enable_In = 1'b1;
        #1;

        // Enable low at slot 4
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, i == 0, FRAME_A[i]);
        checkOutput("en_pre_data", dOut, FRAME_A);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, i == 0, FRAME_B[i]);
        checkOutput("en_pre_slot", {5'd0, Slot_Out}, 8'd4);
        Enable_In = 1'b0;
        #1;
        checkOutput("en_float",
                    {4'h0, Data_6_Out !== 1'b1, Data_3_Out !== 1'b1,
                     Data_2_Out !== 1'b1, Data_0_Out !== 1'b1}, 8'h0F);
        checkBit("en_fv", Frame_Valid_Out, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkBit("en_locked", Locked_Out, 1'b0);
        checkOutput("en_slot", {5'd0, Slot_Out}, 8'd0);
        Enable_In = 1'b1;
        #1;
        checkOutput("en_retain", dOut, FRAME_A);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkBit("en_needs_sync", Locked_Out, 1'b0);

        // Reset at slot 6
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, i == 0, FRAME_B[i]);
        checkOutput("rst6_slot", {5'd0, Slot_Out}, 8'd6);
        Reset_N_In = 1'b0;
        #1;
        checkOutput("rst6_data", dOut, 8'h00);
        checkBit("rst6_fv", Frame_Valid_Out, 1'b0);
        checkBit("rst6_locked", Locked_Out, 1'b0);
        checkOutput("rst6_slotz", {5'd0, Slot_Out}, 8'd0);
        checkBit("rst6_err", Sync_Error_Out, 1'b0);
        @(posedge Clock_In);
        #1;
        Reset_N_In = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkBit("rst6_hunt", Locked_Out, 1'b0);
        checkOutput("rst6_data_hold", dOut, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
